// File: rtl/id_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : id_scoreboard
//  Description : Decode-stage register scoreboard. Keeps one pending-write
//                counter per architectural register (r0 excluded) and a
//                global in-flight write counter. Raises a stall (hazard)
//                when a decoded source still has a pending write, or when
//                a new writer would overflow its register counter or the
//                in-flight budget.
//  Ports       :
//    clk, reset                 clock, asynchronous active-high reset
//    id_valid                   decode stage holds a valid instruction
//    id_rj/id_rk, *_used        source register indices and use flags
//    id_wen, id_rd              destination write enable / index
//    exe_ready                  execute stage can accept an instruction
//    wb_valid, wb_rd            one write retires to wb_rd this cycle
//    flush                      discard all in-flight writes
//    id_ready                   decode may hand off to execute this cycle
//    hazard                     RAW or counter-saturation stall present
//    busy                       at least one write pending
//    inflight                   in-flight write count
//    sb_err                     sticky: writeback with no pending write
//  Revision    : 1.0 - initial release
// ============================================================================
module id_scoreboard #(
    parameter int NREG         = 32,
    parameter int CNT_W        = 2,
    parameter int INFLIGHT_MAX = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       id_valid,
    input  logic [4:0] id_rj,
    input  logic [4:0] id_rk,
    input  logic       id_rj_used,
    input  logic       id_rk_used,
    input  logic       id_wen,
    input  logic [4:0] id_rd,
    input  logic       exe_ready,
    input  logic       wb_valid,
    input  logic [4:0] wb_rd,
    input  logic       flush,
    output logic       id_ready,
    output logic       hazard,
    output logic       busy,
    output logic [2:0] inflight,
    output logic       sb_err
);

    localparam logic [CNT_W-1:0] c_cnt_max      = {CNT_W{1'b1}};
    localparam logic [2:0]       c_inflight_max = 3'(INFLIGHT_MAX);

    // Entry 0 exists only to keep indexing simple; it is never written
    // and never read (r0 lookups return zero directly).
    logic [CNT_W-1:0] r_cnt [NREG];
    logic [2:0]       r_inflight;
    logic             r_sb_err;

    logic [CNT_W-1:0] w_cnt_rj;
    logic [CNT_W-1:0] w_cnt_rk;
    logic [CNT_W-1:0] w_cnt_rd;
    logic [CNT_W-1:0] w_cnt_wb;
    logic             w_raw_hit;
    logic             w_sat_hit;
    logic             w_issue;
    logic             w_retire;
    logic             w_orphan_wb;

    // Counter lookup; r0 and any index at or beyond NREG read as zero.
    function automatic logic [CNT_W-1:0] cnt_of(input logic [4:0] idx);
        cnt_of = '0;
        for (int k = 1; k < NREG; k++) begin
            if (idx == 5'(k)) begin
                cnt_of = r_cnt[k];
            end
        end
    endfunction

    always_comb begin
        w_cnt_rj = cnt_of(id_rj);
        w_cnt_rk = cnt_of(id_rk);
        w_cnt_rd = cnt_of(id_rd);
        w_cnt_wb = cnt_of(wb_rd);
    end

    // Stall decisions use registered state only: a writeback in this cycle
    // does not release a dependent instruction until the next cycle.
    assign w_raw_hit = id_valid &
                       ((id_rj_used & (id_rj != 5'd0) & (w_cnt_rj != '0)) |
                        (id_rk_used & (id_rk != 5'd0) & (w_cnt_rk != '0)));

    assign w_sat_hit = id_valid & id_wen & (id_rd != 5'd0) &
                       ((w_cnt_rd == c_cnt_max) | (r_inflight == c_inflight_max));

    assign hazard   = w_raw_hit | w_sat_hit;
    assign id_ready = exe_ready & ~hazard & ~flush & ~reset;

    assign w_issue     = id_valid & id_ready & id_wen & (id_rd != 5'd0);
    assign w_retire    = wb_valid & (wb_rd != 5'd0) & (w_cnt_wb != '0);
    assign w_orphan_wb = wb_valid & (wb_rd != 5'd0) & (w_cnt_wb == '0);

    // Per-register pending-write counters. Issue and retire hitting the
    // same register cancel out; saturation is prevented by w_sat_hit and
    // underflow by the w_retire qualification.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NREG; k++) begin
                r_cnt[k] <= '0;
            end
        end else if (flush) begin
            for (int k = 0; k < NREG; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            for (int k = 1; k < NREG; k++) begin
                if (w_issue && (id_rd == 5'(k)) && !(w_retire && (wb_rd == 5'(k)))) begin
                    r_cnt[k] <= r_cnt[k] + CNT_W'(1);
                end else if (w_retire && (wb_rd == 5'(k)) && !(w_issue && (id_rd == 5'(k)))) begin
                    r_cnt[k] <= r_cnt[k] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inflight <= 3'd0;
        end else if (flush) begin
            r_inflight <= 3'd0;
        end else if (w_issue && !w_retire) begin
            r_inflight <= r_inflight + 3'd1;
        end else if (w_retire && !w_issue) begin
            r_inflight <= r_inflight - 3'd1;
        end
    end

    // Error flag survives flush; only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sb_err <= 1'b0;
        end else if (w_orphan_wb) begin
            r_sb_err <= 1'b1;
        end
    end

    assign busy     = (r_inflight != 3'd0);
    assign inflight = r_inflight;
    assign sb_err   = r_sb_err;

endmodule
`default_nettype wire

// File: tb/tb_id_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_scoreboard
//  Description : Self-checking bench for id_scoreboard: fixed vector table,
//                directed multi-cycle sequences and a randomized run, all
//                compared against a behavioural scoreboard model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_scoreboard;

    localparam int CNT_MAX = 3;
    localparam int INF_MAX = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_rj_used, id_rk_used, id_wen, exe_ready;
    logic       wb_valid, flush;
    logic [4:0] id_rj, id_rk, id_rd, wb_rd;
    logic       id_ready, hazard, busy, sb_err;
    logic [2:0] inflight;

    id_scoreboard #(.NREG(32), .CNT_W(2), .INFLIGHT_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rj(id_rj), .id_rk(id_rk),
        .id_rj_used(id_rj_used), .id_rk_used(id_rk_used),
        .id_wen(id_wen), .id_rd(id_rd), .exe_ready(exe_ready),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
        .id_ready(id_ready), .hazard(hazard), .busy(busy),
        .inflight(inflight), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [4:0] rj;
        logic       rju;
        logic [4:0] rk;
        logic       rku;
        logic       wen;
        logic [4:0] rd;
        logic       er;
        logic       wbv;
        logic [4:0] wbrd;
        logic       fl;
        logic       rst;
    } in_t;

    typedef struct {
        in_t  i;
        logic exp_ready;
        logic exp_haz;
        int   exp_inf;
        logic exp_err;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Behavioural model: pending writes per register, in-flight total, error flag.
    int m_cnt[32];
    int m_inf;
    bit m_err;
    bit e_haz;
    bit e_ready;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic in_t mk(input logic v, input int rj, input logic rju, input int rk,
                               input logic rku, input logic wen, input int rd, input logic er,
                               input logic wbv, input int wbrd, input logic fl);
        in_t x;
        x.v = v; x.rj = 5'(rj); x.rju = rju; x.rk = 5'(rk); x.rku = rku;
        x.wen = wen; x.rd = 5'(rd); x.er = er; x.wbv = wbv; x.wbrd = 5'(wbrd);
        x.fl = fl; x.rst = 1'b0;
        return x;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 32; k++) m_cnt[k] = 0;
        m_inf = 0;
        m_err = 1'b0;
    endtask

    // Drive one cycle of inputs, compare all outputs against the model,
    // then advance the clock and the model together.
    task automatic step(input in_t x);
        bit issue, retire;
        id_valid = x.v; id_rj = x.rj; id_rj_used = x.rju; id_rk = x.rk; id_rk_used = x.rku;
        id_wen = x.wen; id_rd = x.rd; exe_ready = x.er; wb_valid = x.wbv; wb_rd = x.wbrd;
        flush = x.fl; reset = x.rst;
        #2;
        if (x.rst) model_clear();
        e_haz = x.v && ((x.rju && x.rj != 0 && m_cnt[x.rj] != 0) ||
                        (x.rku && x.rk != 0 && m_cnt[x.rk] != 0) ||
                        (x.wen && x.rd != 0 && (m_cnt[x.rd] == CNT_MAX || m_inf == INF_MAX)));
        e_ready = x.er && !e_haz && !x.fl && !x.rst;
        chk("hazard",   32'(hazard),   32'(e_haz));
        chk("id_ready", 32'(id_ready), 32'(e_ready));
        chk("busy",     32'(busy),     32'(m_inf != 0));
        chk("inflight", 32'(inflight), 32'(m_inf));
        chk("sb_err",   32'(sb_err),   32'(m_err));
        @(posedge clk);
        if (!x.rst) begin
            issue  = x.v && e_ready && x.wen && x.rd != 0;
            retire = x.wbv && x.wbrd != 0 && m_cnt[x.wbrd] != 0;
            if (x.wbv && x.wbrd != 0 && m_cnt[x.wbrd] == 0) m_err = 1'b1;
            if (x.fl) begin
                for (int k = 0; k < 32; k++) m_cnt[k] = 0;
                m_inf = 0;
            end else begin
                if (issue)  begin m_cnt[x.rd]++;   m_inf++; end
                if (retire) begin m_cnt[x.wbrd]--; m_inf--; end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        in_t x;
        x = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        x.rst = 1'b1;
        step(x);
    endtask

    vec_t tbl[16];
    in_t  x;
    in_t  idle;
    in_t  wr7;

    initial begin
        reset = 1'b1; id_valid = 0; id_rj = 0; id_rk = 0; id_rj_used = 0; id_rk_used = 0;
        id_wen = 0; id_rd = 0; exe_ready = 0; wb_valid = 0; wb_rd = 0; flush = 0;
        model_clear();
        idle = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

        // Table: each row is one cycle, run back-to-back from the reset state.
        tbl[0]  = '{mk(0,0,0,0,0,0,0,1,0,0,0), 1'b1, 1'b0, 0, 1'b0};
        tbl[1]  = '{mk(1,0,0,0,0,1,5,1,0,0,0), 1'b1, 1'b0, 0, 1'b0}; // issue rd=5
        tbl[2]  = '{mk(1,5,1,0,0,0,0,1,0,0,0), 1'b0, 1'b1, 1, 1'b0}; // RAW on r5
        tbl[3]  = '{mk(1,5,1,0,0,0,0,1,1,5,0), 1'b0, 1'b1, 1, 1'b0}; // wb r5, no forwarding
        tbl[4]  = '{mk(1,5,1,0,0,0,0,1,0,0,0), 1'b1, 1'b0, 0, 1'b0}; // released
        tbl[5]  = '{mk(1,0,0,0,0,1,3,1,0,0,0), 1'b1, 1'b0, 0, 1'b0}; // issue rd=3
        tbl[6]  = '{mk(1,0,0,0,0,1,3,1,1,3,0), 1'b1, 1'b0, 1, 1'b0}; // issue+wb r3
        tbl[7]  = '{mk(1,0,0,3,1,0,0,1,0,0,0), 1'b0, 1'b1, 1, 1'b0}; // cnt[3] still 1
        tbl[8]  = '{mk(0,0,0,0,0,0,0,1,1,3,0), 1'b1, 1'b0, 1, 1'b0}; // retire r3
        tbl[9]  = '{mk(0,0,0,0,0,0,0,1,0,0,0), 1'b1, 1'b0, 0, 1'b0};
        tbl[10] = '{mk(0,0,0,0,0,0,0,1,1,9,0), 1'b1, 1'b0, 0, 1'b0}; // orphan wb r9
        tbl[11] = '{mk(0,0,0,0,0,0,0,1,0,0,1), 1'b0, 1'b0, 0, 1'b1}; // flush keeps sb_err
        tbl[12] = '{mk(0,0,0,0,0,0,0,1,0,0,0), 1'b1, 1'b0, 0, 1'b1};
        tbl[13] = '{mk(1,0,1,0,1,1,0,1,0,0,0), 1'b1, 1'b0, 0, 1'b1}; // all r0
        tbl[14] = '{mk(0,0,0,0,0,0,0,1,1,0,0), 1'b1, 1'b0, 0, 1'b1}; // wb r0 ignored
        tbl[15] = '{mk(0,0,0,0,0,0,0,1,0,0,0), 1'b1, 1'b0, 0, 1'b1};

        @(posedge clk); @(posedge clk); #1;
        chk("reset_inflight", 32'(inflight), 32'd0);
        chk("reset_ready",    32'(id_ready), 32'd0);
        do_reset();

        for (int n = 0; n < 16; n++) begin
            id_valid = tbl[n].i.v; id_rj = tbl[n].i.rj; id_rj_used = tbl[n].i.rju;
            id_rk = tbl[n].i.rk; id_rk_used = tbl[n].i.rku; id_wen = tbl[n].i.wen;
            id_rd = tbl[n].i.rd; exe_ready = tbl[n].i.er; wb_valid = tbl[n].i.wbv;
            wb_rd = tbl[n].i.wbrd; flush = tbl[n].i.fl; reset = 1'b0;
            #1;
            chk($sformatf("tbl%0d_ready", n),    32'(id_ready), 32'(tbl[n].exp_ready));
            chk($sformatf("tbl%0d_hazard", n),   32'(hazard),   32'(tbl[n].exp_haz));
            chk($sformatf("tbl%0d_inflight", n), 32'(inflight), 32'(tbl[n].exp_inf));
            chk($sformatf("tbl%0d_sb_err", n),   32'(sb_err),   32'(tbl[n].exp_err));
            step(tbl[n].i);
        end

        // sb_err clears only on reset.
        do_reset();
        chk("sb_err_after_reset", 32'(sb_err), 32'd0);

        // Counter saturation on r7.
        wr7 = mk(1, 0, 0, 0, 0, 1, 7, 1, 0, 0, 0);
        for (int n = 0; n < 3; n++) step(wr7);
        x = wr7; x.wbv = 1'b1; x.wbrd = 5'd7;
        id_valid = x.v; id_wen = 1'b1; id_rd = 5'd7; exe_ready = 1'b1; #1;
        chk("sat_hazard", 32'(hazard), 32'd1);
        chk("sat_ready",  32'(id_ready), 32'd0);
        step(x);
        step(wr7);
        x = mk(1, 7, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        id_valid = 1'b1; id_wen = 1'b0; id_rj = 5'd7; id_rj_used = 1'b1; #1;
        chk("sat_refill_inflight", 32'(inflight), 32'd3);
        step(x);
        step(wr7);  // cnt[7]=3, must stall again

        // In-flight limit and flush release.
        do_reset();
        for (int n = 1; n <= 4; n++) step(mk(1, 0, 0, 0, 0, 1, n, 1, 0, 0, 0));
        x = mk(1, 0, 0, 0, 0, 1, 6, 1, 0, 0, 0);
        step(x);                       // fifth writer stalls
        x.fl = 1'b1; step(x);          // flush
        x.fl = 1'b0;
        id_valid = 1'b1; id_wen = 1'b1; id_rd = 5'd6; flush = 1'b0; exe_ready = 1'b1; #1;
        chk("flush_busy",  32'(busy),     32'd0);
        chk("flush_ready", 32'(id_ready), 32'd1);
        step(x);
        step(idle);

        // Reset mid-stream takes effect immediately.
        step(mk(1, 0, 0, 0, 0, 1, 9, 1, 0, 0, 0));
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 12, 0));
        reset = 1'b1; #1;
        chk("async_reset_ready", 32'(id_ready), 32'd0);
        chk("async_reset_busy",  32'(busy),     32'd0);
        chk("async_reset_err",   32'(sb_err),   32'd0);
        do_reset();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            int pick;
            int s;
            int r;
            x.v   = ($urandom_range(0, 3) != 0);
            x.rj  = 5'($urandom_range(0, 7));
            x.rju = $urandom_range(0, 1) == 1;
            x.rk  = 5'($urandom_range(0, 7));
            x.rku = $urandom_range(0, 1) == 1;
            x.wen = ($urandom_range(0, 3) != 0);
            x.rd  = 5'($urandom_range(0, 7));
            x.er  = ($urandom_range(0, 4) != 0);
            x.wbv = $urandom_range(0, 1) == 1;
            pick = -1;
            s = $urandom_range(1, 31);
            for (int k = 0; k < 31; k++) begin
                r = 1 + ((s - 1 + k) % 31);
                if (pick < 0 && m_cnt[r] != 0) pick = r;
            end
            if (pick < 0 || $urandom_range(0, 9) == 0) pick = $urandom_range(0, 10);
            x.wbrd = 5'(pick);
            x.fl  = ($urandom_range(0, 39) == 0);
            x.rst = ($urandom_range(0, 149) == 0);
            step(x);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
